// File: rtl/mod4_addsub_fixed.sv
// mod4_addsub_fixed: pipelined fixed-point adder/subtractor for the module-4 datapath.
// Operands A and B arrive on joined valid/ready handshakes and are always consumed on the same edge.
// Each beat carries its own op (add/sub) and sign mode, which are registered alongside the operands.
// The result is either wrapped or saturated, depending on SATURATE.
// An overflow flag travels with every result.
// A saturating counter records how many delivered beats overflowed.
module mod4_addsub_fixed #(
  parameter int DATA_W   = 16,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] input_tdata_a,
  input  logic              input_tvalid_a,
  output logic              input_tready_a,
  input  logic [DATA_W-1:0] input_tdata_b,
  input  logic              input_tvalid_b,
  output logic              input_tready_b,
  input  logic              op,
  input  logic              sign,
  output logic [DATA_W-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready,
  output logic              overflow,
  output logic [CNT_W-1:0]  overflow_count,
  input  logic              count_clear
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic              r_active;
  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1A;
  logic [DATA_W-1:0] r_s1B;
  logic              r_s1Op;
  logic              r_s1Sign;
  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;
  logic              r_outOvf;
  logic [CNT_W-1:0]  r_ovfCount;

  logic              w_adv;
  logic              w_accept;
  logic              w_countInc;
  logic [DATA_W:0]   w_extA;
  logic [DATA_W:0]   w_extB;
  logic [DATA_W:0]   w_sum;
  logic              w_ovf;
  logic [DATA_W-1:0] w_satVal;
  logic [DATA_W-1:0] w_result;

  // The pipeline advances whenever the output slot is empty or is being drained this cycle.
  // r_active keeps both readies low until the first edge after reset has been released.
  assign w_adv          = ~r_outValid | output_tready;
  assign w_accept       = w_adv & input_tvalid_a & input_tvalid_b & r_active;
  assign input_tready_a = w_accept;
  assign input_tready_b = w_accept;
  assign w_countInc     = r_outValid & output_tready & r_outOvf;

  assign output_tdata   = r_outData;
  assign output_tvalid  = r_outValid;
  assign overflow       = r_outOvf;
  assign overflow_count = r_ovfCount;

  // Set one edge after reset is released, so that reset deassertion takes effect on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_active <= 1'b0;
    else          r_active <= 1'b1;
  end

  // Stage 1: captures the operands and the per-beat mode bits on an accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Op    <= 1'b0;
      r_s1Sign  <= 1'b0;
    end else if (w_adv) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1A    <= input_tdata_a;
        r_s1B    <= input_tdata_b;
        r_s1Op   <= op;
        r_s1Sign <= sign;
      end
    end
  end

  // The sum is formed one bit wider than the operands; the extra bit exposes carry, borrow or signed overflow.
  always_comb begin
    w_extA   = r_s1Sign ? {r_s1A[DATA_W-1], r_s1A} : {1'b0, r_s1A};
    w_extB   = r_s1Sign ? {r_s1B[DATA_W-1], r_s1B} : {1'b0, r_s1B};
    w_sum    = r_s1Op ? (w_extA - w_extB) : (w_extA + w_extB);
    w_ovf    = 1'b0;
    w_satVal = '0;
    if (r_s1Sign) begin
      w_ovf    = w_sum[DATA_W] ^ w_sum[DATA_W-1];
      w_satVal = w_sum[DATA_W] ? SAT_NEG : SAT_POS;
    end else begin
      w_ovf    = w_sum[DATA_W];
      w_satVal = r_s1Op ? '0 : '1;
    end
    w_result = (SATURATE && w_ovf) ? w_satVal : w_sum[DATA_W-1:0];
  end

  // Stage 2: registers the result and its overflow flag; both are held while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outOvf   <= 1'b0;
    end else if (w_adv) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outData <= w_result;
        r_outOvf  <= w_ovf;
      end
    end
  end

  // Counts delivered beats that overflowed and sticks at all-ones.
  // A clear that coincides with an increment leaves the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovfCount <= '0;
    end else if (count_clear) begin
      r_ovfCount <= w_countInc ? CNT_ONE : '0;
    end else if (w_countInc && (r_ovfCount != CNT_MAX)) begin
      r_ovfCount <= r_ovfCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mod4_addsub_fixed.sv
// tb_mod4_addsub_fixed: directed bench for mod4_addsub_fixed.
// A wrapping instance (CNT_W=2) and a saturating instance (CNT_W=8) are driven side by side from the same inputs.
module tb_mod4_addsub_fixed;

  logic        clk;
  logic        reset_n;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        tvalidA;
  logic        tvalidB;
  logic        opIn;
  logic        signIn;
  logic        tready;
  logic        countClear;

  logic        wReadyA, wReadyB, wValid, wOvf;
  logic [15:0] wData;
  logic [1:0]  wCount;
  logic        sReadyA, sReadyB, sValid, sOvf;
  logic [15:0] sData;
  logic [7:0]  sCount;

  int checkCount;
  int passCount;

  logic [15:0] vecA    [10];
  logic [15:0] vecB    [10];
  logic        vecOp   [10];
  logic        vecSign [10];
  logic [15:0] vecWrap [10];
  logic [15:0] vecSat  [10];
  logic        vecOvf  [10];

  mod4_addsub_fixed #(.DATA_W(16), .SATURATE(1'b0), .CNT_W(2)) dutWrap (
    .clk(clk), .reset_n(reset_n),
    .input_tdata_a(inA), .input_tvalid_a(tvalidA), .input_tready_a(wReadyA),
    .input_tdata_b(inB), .input_tvalid_b(tvalidB), .input_tready_b(wReadyB),
    .op(opIn), .sign(signIn),
    .output_tdata(wData), .output_tvalid(wValid), .output_tready(tready),
    .overflow(wOvf), .overflow_count(wCount), .count_clear(countClear)
  );

  mod4_addsub_fixed #(.DATA_W(16), .SATURATE(1'b1), .CNT_W(8)) dutSat (
    .clk(clk), .reset_n(reset_n),
    .input_tdata_a(inA), .input_tvalid_a(tvalidA), .input_tready_a(sReadyA),
    .input_tdata_b(inB), .input_tvalid_b(tvalidB), .input_tready_b(sReadyB),
    .op(opIn), .sign(signIn),
    .output_tdata(sData), .output_tvalid(sValid), .output_tready(tready),
    .overflow(sOvf), .overflow_count(sCount), .count_clear(countClear)
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Sends one beat, checks the output two edges after acceptance, and lets the beat drain.
  task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic o, input logic s, input logic [15:0] expWrap,
                               input logic [15:0] expSat, input logic expOvf, input logic clearAtOut);
    @(negedge clk);
    inA = a; inB = b; opIn = o; signIn = s; tvalidA = 1'b1; tvalidB = 1'b1;
    #1 checkOutput({tag, "_ready"}, {31'd0, wReadyA & wReadyB & sReadyA & sReadyB}, 32'd1);
    @(posedge clk);
    #1 tvalidA = 1'b0; tvalidB = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, {31'd0, wValid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {30'd0, wValid, sValid}, 32'd3);
    checkOutput({tag, "_wrap"}, {16'd0, wData}, {16'd0, expWrap});
    checkOutput({tag, "_sat"}, {16'd0, sData}, {16'd0, expSat});
    checkOutput({tag, "_ovf"}, {30'd0, wOvf, sOvf}, {30'd0, expOvf, expOvf});
    if (clearAtOut) countClear = 1'b1;
    @(posedge clk);
    #1 countClear = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset_n = 1'b0; inA = '0; inB = '0; tvalidA = 1'b1; tvalidB = 1'b1;
    opIn = 1'b0; signIn = 1'b0; tready = 1'b1; countClear = 1'b0;

    // Streaming table: a, b, op, sign, wrapped result, saturated result, overflow.
    vecA[0]=16'h0001; vecB[0]=16'h0002; vecOp[0]=0; vecSign[0]=1; vecWrap[0]=16'h0003; vecSat[0]=16'h0003; vecOvf[0]=0;
    vecA[1]=16'h0010; vecB[1]=16'h0004; vecOp[1]=1; vecSign[1]=1; vecWrap[1]=16'h000C; vecSat[1]=16'h000C; vecOvf[1]=0;
    vecA[2]=16'hFFFF; vecB[2]=16'h0001; vecOp[2]=0; vecSign[2]=0; vecWrap[2]=16'h0000; vecSat[2]=16'hFFFF; vecOvf[2]=1;
    vecA[3]=16'h0005; vecB[3]=16'h0007; vecOp[3]=1; vecSign[3]=1; vecWrap[3]=16'hFFFE; vecSat[3]=16'hFFFE; vecOvf[3]=0;
    vecA[4]=16'h0005; vecB[4]=16'h0007; vecOp[4]=1; vecSign[4]=0; vecWrap[4]=16'hFFFE; vecSat[4]=16'h0000; vecOvf[4]=1;
    vecA[5]=16'h7000; vecB[5]=16'h0100; vecOp[5]=0; vecSign[5]=1; vecWrap[5]=16'h7100; vecSat[5]=16'h7100; vecOvf[5]=0;
    vecA[6]=16'h8000; vecB[6]=16'h8000; vecOp[6]=0; vecSign[6]=0; vecWrap[6]=16'h0000; vecSat[6]=16'hFFFF; vecOvf[6]=1;
    vecA[7]=16'h8000; vecB[7]=16'h8000; vecOp[7]=0; vecSign[7]=1; vecWrap[7]=16'h0000; vecSat[7]=16'h8000; vecOvf[7]=1;
    vecA[8]=16'h1234; vecB[8]=16'h4321; vecOp[8]=0; vecSign[8]=0; vecWrap[8]=16'h5555; vecSat[8]=16'h5555; vecOvf[8]=0;
    vecA[9]=16'h00FF; vecB[9]=16'h00FF; vecOp[9]=1; vecSign[9]=1; vecWrap[9]=16'h0000; vecSat[9]=16'h0000; vecOvf[9]=0;

    // Reset state, with both valids asserted to show that the readies stay low.
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {30'd0, wValid, sValid}, 32'd0);
    checkOutput("rst_data", {wData, sData}, 32'd0);
    checkOutput("rst_ovf", {30'd0, wOvf, sOvf}, 32'd0);
    checkOutput("rst_count", {22'd0, wCount, sCount}, 32'd0);
    checkOutput("rst_ready", {28'd0, wReadyA, wReadyB, sReadyA, sReadyB}, 32'd0);
    tvalidA = 1'b0; tvalidB = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed arithmetic beats.
    applyStimulus("sadd",     16'h4000, 16'h2000, 1'b0, 1'b1, 16'h6000, 16'h6000, 1'b0, 1'b0);
    applyStimulus("saddOvf",  16'h6000, 16'h4000, 1'b0, 1'b1, 16'hA000, 16'h7FFF, 1'b1, 1'b0);
    applyStimulus("ssubOvf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
    applyStimulus("usubOvf",  16'h2000, 16'h4000, 1'b1, 1'b0, 16'hE000, 16'h0000, 1'b1, 1'b0);
    applyStimulus("uaddOvf",  16'hC000, 16'h8000, 1'b0, 1'b0, 16'h4000, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus("uadd",     16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 16'h1235, 1'b0, 1'b0);
    applyStimulus("ssubNeg",  16'h1000, 16'h3000, 1'b1, 1'b1, 16'hE000, 16'hE000, 1'b0, 1'b0);
    checkOutput("cnt_wrapHeld", {30'd0, wCount}, 32'd3);
    checkOutput("cnt_sat", {24'd0, sCount}, 32'd4);

    // Clear coinciding with an overflow handshake, then clear alone.
    applyStimulus("clrInc",   16'h6000, 16'h4000, 1'b0, 1'b1, 16'hA000, 16'h7FFF, 1'b1, 1'b1);
    checkOutput("cnt_clrIncW", {30'd0, wCount}, 32'd1);
    checkOutput("cnt_clrIncS", {24'd0, sCount}, 32'd1);
    @(negedge clk);
    countClear = 1'b1;
    @(posedge clk);
    #1 countClear = 1'b0;
    checkOutput("cnt_clrOnly", {22'd0, wCount, sCount}, 32'd0);

    // A lone valid on A is never consumed; B joining it produces exactly one beat.
    @(negedge clk);
    inA = 16'h0100; inB = 16'h0200; opIn = 1'b0; signIn = 1'b1; tvalidA = 1'b1; tvalidB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput("lone_ready", {30'd0, wReadyA, wReadyB}, 32'd0);
      checkOutput("lone_noOut", {31'd0, wValid}, 32'd0);
      @(negedge clk);
    end
    tvalidB = 1'b1;
    #1 checkOutput("join_ready", {30'd0, wReadyA, wReadyB}, 32'd3);
    @(posedge clk);
    #1 tvalidA = 1'b0; tvalidB = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("join_valid", {31'd0, wValid}, 32'd1);
    checkOutput("join_data", {16'd0, wData}, 32'h0300);
    @(negedge clk);
    checkOutput("join_single", {31'd0, wValid}, 32'd0);

    // Back-to-back stream of mixed beats with a five-cycle downstream stall in the middle.
    @(posedge clk);
    #1;
    fork
      begin : producer
        int idx;
        int guard;
        logic acc;
        idx = 0; guard = 0;
        inA = vecA[0]; inB = vecB[0]; opIn = vecOp[0]; signIn = vecSign[0];
        tvalidA = 1'b1; tvalidB = 1'b1;
        while (idx < 10 && guard < 80) begin
          @(negedge clk);
          acc = wReadyA;
          @(posedge clk);
          #1 guard++;
          if (acc) begin
            idx++;
            if (idx < 10) begin
              inA = vecA[idx]; inB = vecB[idx]; opIn = vecOp[idx]; signIn = vecSign[idx];
            end else begin
              tvalidA = 1'b0; tvalidB = 1'b0;
            end
          end
        end
        tvalidA = 1'b0; tvalidB = 1'b0;
      end
      begin : consumer
        int k;
        int cyc;
        k = 0; cyc = 0;
        while (k < 10 && cyc < 80) begin
          @(negedge clk);
          cyc++;
          if (wValid) begin
            checkOutput($sformatf("stream%0d_wrap", k), {16'd0, wData}, {16'd0, vecWrap[k]});
            checkOutput($sformatf("stream%0d_sat", k), {16'd0, sData}, {16'd0, vecSat[k]});
            checkOutput($sformatf("stream%0d_ovf", k), {31'd0, wOvf}, {31'd0, vecOvf[k]});
            if (tready) k++;
          end
        end
        checkOutput("stream_delivered", k, 32'd10);
        @(negedge clk);
        checkOutput("stream_noExtra", {31'd0, wValid}, 32'd0);
      end
      begin : staller
        repeat (4) @(posedge clk);
        #1 tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 tready = 1'b1;
      end
    join
    checkOutput("stream_cntW", {30'd0, wCount}, 32'd3);
    checkOutput("stream_cntS", {24'd0, sCount}, 32'd4);

    // Reset asserted while beats are in flight clears everything, and the beats never appear.
    @(negedge clk);
    inA = 16'h0001; inB = 16'h0001; opIn = 1'b0; signIn = 1'b1; tvalidA = 1'b1; tvalidB = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_inflight", {31'd0, wValid}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {30'd0, wValid, sValid}, 32'd0);
    checkOutput("midrst_data", {wData, sData}, 32'd0);
    checkOutput("midrst_ovf", {30'd0, wOvf, sOvf}, 32'd0);
    checkOutput("midrst_count", {22'd0, wCount, sCount}, 32'd0);
    checkOutput("midrst_ready", {28'd0, wReadyA, wReadyB, sReadyA, sReadyB}, 32'd0);
    tvalidA = 1'b0; tvalidB = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_dropped", {30'd0, wValid, sValid}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
